priority_encoder_fifo: RTL and testbench

PRIORITY_ENCODER_FIFO -- requirements
Module: priority_encoder_fifo

---
 rtl/priority_encoder_fifo.sv | 98 +++++++++
 tb/tb_priority_encoder_fifo.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/priority_encoder_fifo.sv
// priority_encoder_fifo: highest-index priority encoder feeding a small
// result queue with valid/ready handshakes on both sides.
// Optional feature: define ENC_MULTIHOT_FLAG_EN to add out_multi, a per-entry
// flag marking captures whose request vector had more than one bit set.
module priority_encoder_fifo #(
  parameter int N     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N-1:0]               in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [$clog2(N)-1:0]       out_code,
  output logic                       out_zero,
  output logic                       out_valid,
  input  logic                       out_ready,
`ifdef ENC_MULTIHOT_FLAG_EN
  output logic                       out_multi,
`endif
  output logic [$clog2(DEPTH):0]     count
);

  localparam int W  = $clog2(N);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  typedef struct packed {
`ifdef ENC_MULTIHOT_FLAG_EN
    logic         multi;
`endif
    logic [W-1:0] code;
    logic         zero;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        enc;
  entry_t        head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // Handshakes depend only on registered occupancy, never on the other side.
  assign in_ready  = (count != CNT_FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Encoder: later (higher) set bits override earlier ones, so the last hit wins.
  always_comb begin
    enc      = '0;
    enc.zero = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (in_data[i]) begin
        enc.code = W'(i);
        enc.zero = 1'b0;
      end
    end
`ifdef ENC_MULTIHOT_FLAG_EN
    // Clearing the lowest set bit leaves something only if two or more were set.
    enc.multi = |(in_data & (in_data - {{(N-1){1'b0}}, 1'b1}));
`endif
  end

  // Head entry is masked to zero while the queue is empty so stale storage never leaks.
  always_comb begin
    head     = mem[rd_ptr];
    out_code = out_valid ? head.code : '0;
    out_zero = out_valid ? head.zero : 1'b0;
`ifdef ENC_MULTIHOT_FLAG_EN
    out_multi = out_valid ? head.multi : 1'b0;
`endif
  end

  // Queue storage: written on accepted pushes only; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= enc;
  end

  // Pointers and occupancy; reset wins over any concurrent push/pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_priority_encoder_fifo.sv
// Scoreboard bench for priority_encoder_fifo (N=8, DEPTH=4): a queue model
// tracks accepted requests; a negedge monitor compares the DUT against it.
module tb_priority_encoder_fifo;

  localparam int N     = 8;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   out_code;
  logic         out_zero;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [2:0]   count;
  logic         multi_obs;
`ifdef ENC_MULTIHOT_FLAG_EN
  logic         out_multi;
  assign multi_obs = out_multi;
`else
  assign multi_obs = 1'b0;
`endif

  priority_encoder_fifo #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_code(out_code), .out_zero(out_zero), .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef ENC_MULTIHOT_FLAG_EN
    .out_multi(out_multi),
`endif
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int code;
    bit zero;
    bit multi;
  } exp_t;

  exp_t mq[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Reference encoding: scan from the top, first set bit found is the answer.
  function automatic exp_t model(input logic [N-1:0] d);
    exp_t e;
    bit   found = 0;
    e.code  = 0;
    e.zero  = (d == '0);
    e.multi = ($countones(d) > 1);
    for (int b = N-1; b >= 0; b--)
      if (d[b] && !found) begin
        e.code = b;
        found  = 1;
      end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Model update at the active edge: decisions taken on model occupancy.
  always @(posedge clk) begin
    int  sz;
    bit  do_pop, do_push;
    sz = mq.size();
    if (!rst_n) mq.delete();
    else begin
      do_pop  = out_ready && (sz > 0);
      do_push = in_valid && (sz < DEPTH);
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(model(in_data));
    end
  end

  // Monitor: sample away from the active edge and compare against the model.
  always @(negedge clk) begin
    chk("count", 32'(count), mq.size());
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
    if (mq.size() != 0) begin
      chk("head_code", 32'(out_code), mq[0].code);
      chk("head_zero", 32'(out_zero), 32'(mq[0].zero));
`ifdef ENC_MULTIHOT_FLAG_EN
      chk("head_multi", 32'(multi_obs), 32'(mq[0].multi));
`endif
    end else begin
      chk("idle_code", 32'(out_code), 0);
      chk("idle_zero", 32'(out_zero), 0);
      chk("idle_multi", 32'(multi_obs), 0);
    end
  end

  // One cycle of stimulus: drive, wait for the edge, settle.
  task automatic cyc(input logic v, input logic [N-1:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N-1:0] d;
    logic [7:0]   fill [4];
    fill[0] = 8'h01; fill[1] = 8'h10; fill[2] = 8'h80; fill[3] = 8'h00;

    // Reset then idle.
    cyc(0, '0, 0);
    cyc(0, '0, 0);
    rst_n = 1'b1;
    cyc(0, '0, 1);
    chk("rst_count", 32'(count), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_code", 32'(out_code), 0);

    // Fill with out_ready low, then drain: codes 0,4,7,0 zero 0,0,0,1.
    for (int i = 0; i < 4; i++) cyc(1, fill[i], 0);
    chk("full_count", 32'(count), 4);
    chk("full_in_ready", 32'(in_ready), 0);
    for (int i = 0; i < 4; i++) begin
      chk("drain_code", 32'(out_code), (i == 1) ? 4 : (i == 2) ? 7 : 0);
      chk("drain_zero", 32'(out_zero), (i == 3) ? 1 : 0);
      cyc(0, '0, 1);
    end
    chk("drained_count", 32'(count), 0);

    // Full queue with push and pop together: pop only, 0x40 dropped.
    for (int i = 0; i < 4; i++) cyc(1, 8'h03, 0);
    cyc(1, 8'h40, 1);
    chk("full_pushpop_count", 32'(count), 3);
    for (int i = 0; i < 3; i++) cyc(0, '0, 1);
    chk("no_0x40_count", 32'(count), 0);

    // Two queued, simultaneous push 0x0C and pop: count holds, new entry code 3.
    cyc(1, 8'h01, 0);
    cyc(1, 8'h20, 0);
    cyc(1, 8'h0C, 1);
    chk("pushpop_count", 32'(count), 2);
    cyc(0, '0, 1);
    chk("pushpop_new_code", 32'(out_code), 3);
    cyc(0, '0, 1);

    // Reset mid-operation with a live push and pop; queue discarded.
    for (int i = 0; i < 3; i++) cyc(1, 8'hFF, 0);
    rst_n = 1'b0;
    cyc(1, 8'h80, 1);
    rst_n = 1'b1;
    chk("midrst_count", 32'(count), 0);
    chk("midrst_out_valid", 32'(out_valid), 0);
    cyc(1, 8'h02, 0);
    chk("post_rst_code", 32'(out_code), 1);
    cyc(0, '0, 1);

`ifdef ENC_MULTIHOT_FLAG_EN
    cyc(1, 8'h24, 0);
    cyc(1, 8'h08, 0);
    chk("multi_first", 32'(multi_obs), 1);
    chk("multi_first_code", 32'(out_code), 5);
    cyc(0, '0, 1);
    chk("multi_second", 32'(multi_obs), 0);
    chk("multi_second_code", 32'(out_code), 3);
    cyc(0, '0, 1);
`endif

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(3))
        0:       d = '0;
        1:       d = N'(1) << $urandom_range(N-1);
        default: d = N'($urandom);
      endcase
      rst_n = ($urandom_range(99) != 0);
      cyc(($urandom_range(2) != 0), d, $urandom_range(1) == 1);
    end
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) cyc(0, '0, 1);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
